// File: rtl/div_result_queue.sv
// div_result_queue
//
// Collects quotients from a fixed-latency pipelined divider and hands them to
// a consumer over a valid/ready stream with backpressure. Issue is gated by a
// credit counter so every operation in flight already owns a FIFO slot; the
// divider therefore never produces a result with nowhere to store it.
//
// Each accepted issue carries a tag that travels down a {valid, tag} delay
// line of LATENCY stages, matched to the divider. When the last stage is
// valid, the divider's quotient and divide-by-zero flag are joined with the
// exiting tag and pushed into a DEPTH-entry circular FIFO.
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are high. Valid never waits on ready. Once valid is high,
// valid and its data hold stable until that transfer completes.
//
// Optional feature, enabled by defining DIV_RESULT_QUEUE_BYPASS_EN: when the
// FIFO is empty, an exiting result is presented combinationally in the same
// cycle. If the consumer takes it, the result is never written into the FIFO.
// Without the macro every result is registered and the outputs have no
// combinational path from divOut.
//
// Parameters:
//   A       quotient width (matches the divider)
//   LATENCY divider latency in cycles (>= 1)
//   DEPTH   results in flight plus stored, also FIFO entries (>= 1)
//   TAG     tag width
//
// Ports:
//   clock, reset               single clock, asynchronous active-high reset
//   issueValid, issueTag       operation driven onto the divider, and its tag
//   issueReady                 a credit is available (occupancy < DEPTH)
//   divOut, divByZero          divider quotient and divide-by-zero flag
//   outValid, outReady         result stream handshake
//   outQuot, outDivByZero,
//   outTag                     result payload
//   protocolError              sticky: issueValid seen while issueReady low
module div_result_queue #(
    parameter int A       = 16,
    parameter int LATENCY = 17,
    parameter int DEPTH   = 4,
    parameter int TAG     = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           issueValid,
    input  logic [TAG-1:0] issueTag,
    output logic           issueReady,
    input  logic [A-1:0]   divOut,
    input  logic           divByZero,
    output logic           outValid,
    input  logic           outReady,
    output logic [A-1:0]   outQuot,
    output logic           outDivByZero,
    output logic [TAG-1:0] outTag,
    output logic           protocolError
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = A + 1 + TAG;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    // Credit counter: operations in flight in the divider plus stored results.
    logic [CW-1:0]  occ_q, occ_d;
    // Delay line matched to the divider.
    logic [LATENCY-1:0] vld_q;
    logic [TAG-1:0]     tag_q [LATENCY];
    // Result FIFO: entry = {quotient, divByZero, tag}.
    logic [EW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           perr_q, perr_d;

    logic           issue_acc;
    logic           exit_valid;
    logic [EW-1:0]  exit_entry;
    logic [EW-1:0]  head;
    logic [EW-1:0]  out_entry;
    logic           fifo_empty;
    logic           pop;
    logic           fifo_pop;
    logic           push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign issueReady    = (occ_q < DEPTH_C);
    assign protocolError = perr_q;

    always_comb begin
        issue_acc  = issueValid && issueReady;
        exit_valid = vld_q[LATENCY-1];
        exit_entry = {divOut, divByZero, tag_q[LATENCY-1]};
        fifo_empty = (cnt_q == '0);
        head       = mem_q[rd_ptr_q];

`ifdef DIV_RESULT_QUEUE_BYPASS_EN
        // An empty FIFO lets the exiting result go straight to the outputs;
        // if it is taken this cycle it skips the FIFO entirely.
        if (fifo_empty) begin
            outValid  = exit_valid;
            out_entry = exit_valid ? exit_entry : head;
        end else begin
            outValid  = 1'b1;
            out_entry = head;
        end
        pop      = outValid && outReady;
        fifo_pop = pop && !fifo_empty;
        push     = exit_valid && !(fifo_empty && outReady);
`else
        outValid  = !fifo_empty;
        out_entry = head;
        pop       = outValid && outReady;
        fifo_pop  = pop;
        push      = exit_valid;
`endif

        outQuot      = out_entry[EW-1 -: A];
        outDivByZero = out_entry[TAG];
        outTag       = out_entry[TAG-1:0];

        // Credit counter: an issue and a pop in the same cycle cancel.
        occ_d = occ_q;
        case ({issue_acc, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        cnt_d = cnt_q;
        case ({push, fifo_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        wr_ptr_d = push     ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = fifo_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        perr_d = perr_q || (issueValid && !issueReady);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ_q    <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            perr_q   <= 1'b0;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
            // Cleared so the data outputs read 0 out of reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            perr_q   <= perr_d;

            // The divider never stalls, so neither does the delay line.
            vld_q[0] <= issue_acc;
            tag_q[0] <= issueTag;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end

            if (push) mem_q[wr_ptr_q] <= exit_entry;
        end
    end

endmodule

// File: tb/tb_div_result_queue.sv
module tb_div_result_queue;

    localparam int A       = 16;
    localparam int LATENCY = 17;
    localparam int DEPTH   = 4;
    localparam int TAG     = 4;
    localparam int EW      = A + 1 + TAG;
`ifdef DIV_RESULT_QUEUE_BYPASS_EN
    localparam int LAT_EXP = LATENCY;
`else
    localparam int LAT_EXP = LATENCY + 1;
`endif

    // ---------------- clock / reset ----------------
    logic           clock = 1'b0;
    logic           reset = 1'b1;
    always #5 clock = ~clock;

    logic           issueValid = 1'b0;
    logic [TAG-1:0] issueTag   = '0;
    logic           issueReady;
    logic [A-1:0]   divOut;
    logic           divByZero;
    logic           outValid;
    logic           outReady   = 1'b0;
    logic [A-1:0]   outQuot;
    logic           outDivByZero;
    logic [TAG-1:0] outTag;
    logic           protocolError;

    // Operands fed to the divider model.
    logic [A-1:0]   div_a = '0;
    logic [A-1:0]   div_b = '1;

    div_result_queue #(.A(A), .LATENCY(LATENCY), .DEPTH(DEPTH), .TAG(TAG)) dut (
        .clock        (clock),
        .reset        (reset),
        .issueValid   (issueValid),
        .issueTag     (issueTag),
        .issueReady   (issueReady),
        .divOut       (divOut),
        .divByZero    (divByZero),
        .outValid     (outValid),
        .outReady     (outReady),
        .outQuot      (outQuot),
        .outDivByZero (outDivByZero),
        .outTag       (outTag),
        .protocolError(protocolError)
    );

    // ---------------- divider model ----------------
    // Fixed-latency pipeline; stage 0 loads on the same edge the DUT samples
    // the issue. Cycles without an issue carry random garbage.
    logic [A-1:0] q_pipe [LATENCY];
    logic         z_pipe [LATENCY];

    function automatic logic [A-1:0] quot(input logic [A-1:0] a, input logic [A-1:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

    always @(posedge clock) begin
        q_pipe[0] <= issueValid ? quot(div_a, div_b) : A'($urandom);
        z_pipe[0] <= issueValid ? (div_b == '0) : 1'($urandom);
        for (int i = 1; i < LATENCY; i++) begin
            q_pipe[i] <= q_pipe[i-1];
            z_pipe[i] <= z_pipe[i-1];
        end
    end
    assign divOut    = q_pipe[LATENCY-1];
    assign divByZero = z_pipe[LATENCY-1];

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    int  exp_occ  = 0;
    logic exp_perr = 1'b0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Samples on the falling edge, between the bench's input changes
    // (posedge+1) and the next active edge.
    always @(negedge clock) begin
        logic acc, pp;
        logic [EW-1:0] e;
        if (reset) begin
            exp_q.delete();
            exp_occ  = 0;
            exp_perr = 1'b0;
        end else begin
            check("issueReady", 32'(issueReady), 32'(exp_occ < DEPTH));
            check("protocolError", 32'(protocolError), 32'(exp_perr));
            pp = outValid && outReady;
            if (pp) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", 32'(outValid), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'({outQuot, outDivByZero, outTag}), 32'(e));
                end
            end
            acc = issueValid && (exp_occ < DEPTH);
            if (issueValid && !(exp_occ < DEPTH)) exp_perr = 1'b1;
            exp_occ = exp_occ + int'(acc) - int'(pp);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [TAG-1:0] t, input logic [A-1:0] a, input logic [A-1:0] b);
        issueValid = 1'b1;
        issueTag   = t;
        div_a      = a;
        div_b      = b;
        if (exp_occ < DEPTH) exp_q.push_back({quot(a, b), (b == '0), t});
        @(posedge clock); #1;
        issueValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic drain();
        int n = 0;
        outReady = 1'b1;
        while ((exp_q.size() != 0 || exp_occ != 0) && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check("drain_done", 32'(exp_q.size() == 0 && exp_occ == 0), 32'(1));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clock); #1;
            issueValid = 1'b0;
            n++;
        end while (!outValid && n < 60);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        repeat (2) @(posedge clock);
        #1;
        check("rst_outValid", 32'(outValid), 32'(0));
        check("rst_issueReady", 32'(issueReady), 32'(1));
        check("rst_protocolError", 32'(protocolError), 32'(0));
        check("rst_data", 32'({outQuot, outDivByZero, outTag}), 32'(0));
        reset = 1'b0;
        idle(2);

        // Single issue, tag 3, 21/3 = 7: latency and payload.
        outReady   = 1'b0;
        issueValid = 1'b1;
        issueTag   = 4'd3;
        div_a      = 16'd21;
        div_b      = 16'd3;
        exp_q.push_back({16'd7, 1'b0, 4'd3});
        wait_valid(n);
        check("latency", 32'(n), 32'(LAT_EXP));
        check("single_quot", 32'(outQuot), 32'h7);
        check("single_tag", 32'(outTag), 32'h3);
        check("single_dbz", 32'(outDivByZero), 32'h0);
        idle(3);
        check("single_hold", 32'({outValid, outQuot, outTag}), 32'({1'b1, 16'd7, 4'd3}));
        drain();

        // Back-to-back tags 0..3 with the consumer stalled.
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) issue(TAG'(i), A'(100 + i * 17), A'(i + 2));
        check("full_issueReady", 32'(issueReady), 32'(0));
        // Issue while not ready: dropped, flags protocolError.
        issueValid = 1'b1;
        issueTag   = 4'd9;
        div_a      = 16'd50;
        div_b      = 16'd5;
        @(posedge clock); #1;
        issueValid = 1'b0;
        check("perr_set", 32'(protocolError), 32'(1));
        check("perr_still_full", 32'(issueReady), 32'(0));
        idle(LATENCY + 3);
        check("full_head_valid", 32'(outValid), 32'(1));
        check("full_head_tag", 32'(outTag), 32'(0));
        drain();
        check("after_drain_ready", 32'(issueReady), 32'(1));
        check("perr_sticky", 32'(protocolError), 32'(1));

        // Divide by zero, tag 5.
        outReady = 1'b0;
        issue(4'd5, 16'd100, 16'd0);
        wait_valid(n);
        check("dbz_flag", 32'(outDivByZero), 32'(1));
        check("dbz_tag", 32'(outTag), 32'(5));
        drain();

        // Steady stream with outReady toggling 1010...; issue whenever a
        // credit is available.
        for (int i = 0; i < 80; i++) begin
            outReady = (i % 2 == 0);
            if (exp_occ < DEPTH)
                issue(TAG'($urandom_range(0, 15)), A'($urandom), A'($urandom_range(1, 300)));
            else
                idle(1);
        end
        drain();

        // Reset with three results in flight.
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) issue(TAG'(i + 10), A'(1000 + i), A'(3));
        idle(4);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_outValid", 32'(outValid), 32'(0));
        check("midrst_issueReady", 32'(issueReady), 32'(1));
        check("midrst_protocolError", 32'(protocolError), 32'(0));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < LATENCY + 5; i++) begin
            @(posedge clock); #1;
            check("post_rst_no_output", 32'(outValid), 32'(0));
        end

        // Normal service after reset.
        issue(4'd6, 16'd90, 16'd9);
        drain();
        check("final_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
